// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared states, widths and default timeout for the bus arbiter.
package bus_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int SEL_W = 4;
  localparam int WD_W = 8;
  localparam int TIMEOUT_DEF = 255;
  localparam logic [SEL_W-1:0] SEL_ALL = 4'hF;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DRAIN} state_t;
endpackage

// File: rtl/bus_arbiter_watchdog.sv
// bus_watchdog: counts wait cycles of a bus access and flags the abort cycle.
module bus_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);
  logic [WD_W-1:0] cnt;
  // fires on the wait cycle whose increment would reach TIMEOUT-1
  assign expire = run && (cnt + 8'd1 == 8'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= cnt + 8'd1;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: arbitrates fetch and data requests onto a single registered bus master port.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              bus_cyc,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);
  state_t state, state_d;
  logic cyc_d, we_d, if_ready_d, mem_ready_d, clr, expire, done;
  logic [SEL_W-1:0] sel_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, if_rdata_d, mem_rdata_d;
  assign stallreq_if = if_req & ~if_ready;
  assign stallreq_mem = mem_req & ~mem_ready;
  assign bus_stb = bus_cyc;
  assign done = bus_ack | expire;
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .run(state != IDLE && !bus_ack),
    .expire(expire)
  );
  // a requester whose ready pulse is up this cycle is finished, so only stalled requesters are accepted
  always_comb begin
    state_d = state;
    cyc_d = bus_cyc;
    we_d = bus_we;
    sel_d = bus_sel;
    addr_d = bus_addr;
    wdata_d = bus_wdata;
    if_rdata_d = if_rdata;
    mem_rdata_d = mem_rdata;
    if_ready_d = 1'b0;
    mem_ready_d = 1'b0;
    clr = 1'b0;
    case (state)
      IDLE:
        if (stallreq_mem) begin
          state_d = BUSY_MEM;
          cyc_d = 1'b1;
          we_d = mem_we;
          sel_d = mem_sel;
          addr_d = mem_addr;
          wdata_d = mem_wdata;
          clr = 1'b1;
        end else if (stallreq_if && !if_flush) begin
          state_d = BUSY_IF;
          cyc_d = 1'b1;
          we_d = 1'b0;
          sel_d = SEL_ALL;
          addr_d = if_addr;
          clr = 1'b1;
        end
      BUSY_IF:
        if (done) begin
          state_d = IDLE;
          cyc_d = 1'b0;
          if_ready_d = ~if_flush;
          if_rdata_d = if_flush ? if_rdata : bus_ack ? bus_rdata : '0;
        end else if (if_flush) begin
          state_d = DRAIN;
          clr = 1'b1;
        end
      BUSY_MEM:
        if (done) begin
          state_d = IDLE;
          cyc_d = 1'b0;
          mem_ready_d = 1'b1;
          mem_rdata_d = (bus_ack && !bus_we) ? bus_rdata : '0;
        end
      DRAIN:
        if (done) begin
          state_d = IDLE;
          cyc_d = 1'b0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      bus_cyc <= 1'b0;
      bus_we <= 1'b0;
      bus_sel <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      if_rdata <= '0;
      mem_rdata <= '0;
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_d;
      bus_cyc <= cyc_d;
      bus_we <= we_d;
      bus_sel <= sel_d;
      bus_addr <= addr_d;
      bus_wdata <= wdata_d;
      if_rdata <= if_rdata_d;
      mem_rdata <= mem_rdata_d;
      if_ready <= if_ready_d;
      mem_ready <= mem_ready_d;
      bus_err <= expire;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max bus cycles without ack before abort (range 2..255).
REQ-002 Parameters ADDR_W 32 and DATA_W 32: address and data widths.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous reset, active-low.
REQ-005 if_req / if_addr  in  1 / 32  fetch request and its byte address.
REQ-006 if_flush  in  1  discard any outstanding fetch result.
REQ-007 if_rdata / if_ready  out  32 / 1  fetched word; one-cycle completion pulse.
REQ-008 mem_req / mem_we / mem_sel / mem_addr / mem_wdata  in  1 / 1 / 4 / 32 / 32  data-access request.
REQ-009 mem_rdata / mem_ready  out  32 / 1  load data; one-cycle completion pulse.
REQ-010 stallreq_if / stallreq_mem  out  1 / 1  stall requests to the pipeline controller.
REQ-011 bus_cyc, bus_stb, bus_we  out  1 each;  bus_sel out 4;  bus_addr, bus_wdata out 32  registered master port.
REQ-012 bus_rdata in 32; bus_ack in 1  slave response.
REQ-013 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-014 States: IDLE, BUSY_IF, BUSY_MEM, DRAIN (fetch flushed while in flight).
REQ-015 IDLE: mem_req wins over if_req when both high; chosen request registered onto bus, cyc=stb=1 next cycle.
REQ-016 bus_we=mem_we and bus_sel=mem_sel for data accesses; bus_we=0, bus_sel=4'hF for fetches.
REQ-017 Bus outputs held stable through the whole access; request inputs sampled only in IDLE.
REQ-018 On bus_ack in BUSY_X: capture bus_rdata, drop cyc/stb next cycle, X_ready=1 for exactly one cycle, return to IDLE.
REQ-019 Minimum latency: request in IDLE at cycle 0, ack at cycle 1, ready at cycle 2; at most one access per 2 cycles.
REQ-020 mem_rdata forced 0 for stores; rdata outputs hold last value when ready low.
REQ-021 stallreq_X = X_req & ~X_ready (combinational), so requester stalls until its pulse.
REQ-022 if_flush in BUSY_IF: go to DRAIN; cycle runs to ack (never aborted mid-cycle); data discarded, no if_ready.
REQ-023 if_flush in IDLE or BUSY_MEM: no effect on data access; a pending if_req is re-sampled next IDLE.
REQ-024 8-bit watchdog cleared on entering any BUSY/DRAIN state, incremented each cycle without ack.
REQ-025 Watchdog equal to TIMEOUT-1 without ack: drop cyc/stb, pulse bus_err and the owner's ready with rdata 0, return to IDLE.
REQ-026 bus_ack in IDLE is ignored.

Reset
REQ-027 rst low: state IDLE immediately; cyc, stb, we, ready, bus_err 0; sel, addr, wdata, rdata outputs 0; watchdog 0.
REQ-028 Reset mid-access: transaction dropped, no ready pulse after rst releases.

Structure
REQ-029 State encoding, bus width constants and TIMEOUT default in the shared defines package.
REQ-030 One sub-module: bus_watchdog (counter, clear, expire flag).

Verification
REQ-031 Fetch at 0x0000_0100, ack 1 cycle after stb with 0x2402_0005 -> if_ready at cycle 2, if_rdata 0x2402_0005, stallreq_if high cycles 0-1.
REQ-032 if_req and mem_req same cycle (store 0xDEAD_BEEF to 0x80, sel 4'hF) -> bus_we=1 first; fetch issued after mem_ready.
REQ-033 Flush at cycle 1 of fetch with ack at cycle 3 -> no if_ready, next fetch starts cycle 5.
REQ-034 No ack, TIMEOUT=4 -> bus_err and if_ready pulse at cycle 4 (stb rises cycle 1), if_rdata 0, cyc low afterwards.
REQ-035 rst low during BUSY_MEM -> cyc low asynchronously, no mem_ready after release, next request served normally.
REQ-036 Load byte sel 4'b0010 at 0x81, ack data 0x0000_AB00 after 3 wait cycles -> mem_rdata 0x0000_AB00, bus_sel 4'b0010 throughout.
